// File: rtl/wb_mux_pkg.sv
// Shared constants and types for the write-back select mux.
// Optional parity output is enabled by defining WB_MUX2_PARITY_EN.
package wb_mux_pkg;

    localparam int WB_WIDTH = 16;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef logic [WB_WIDTH-1:0] wb_word_t;

endpackage

// File: rtl/wb_mux2_reg.sv
// Valid-qualified write-back register: captures the selected word on in_valid.
// Define WB_MUX2_PARITY_EN to add an even-parity bit registered alongside out_q.
module wb_mux2_reg
    import wb_mux_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
`ifdef WB_MUX2_PARITY_EN
    ,
    output logic             out_par
`endif
);

    // NOTE: non-blocking assignments keep all flops sampling the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= d;
            end
        end
    end

`ifdef WB_MUX2_PARITY_EN
    // Parity tracks out_q exactly: same enable, same reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (in_valid) begin
            out_par <= ^d;
        end
    end
`endif

endmodule

// File: rtl/wb_mux2.sv
// Write-back select mux: combinational ALU/load select plus a registered copy.
// Define WB_MUX2_PARITY_EN to add the out_par output.
module wb_mux2
    import wb_mux_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
`ifdef WB_MUX2_PARITY_EN
    ,
    output logic             out_par
`endif
);

    // Unregistered and unreset so same-cycle consumers see it even during reset.
    assign out = (select == WB_SEL_MEM) ? in1 : in0;

    wb_mux2_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (out),
        .in_valid (in_valid),
        .out_q    (out_q),
        .out_valid(out_valid)
`ifdef WB_MUX2_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

endmodule

// File: tb/tb_wb_mux2.sv
// Self-checking bench for wb_mux2 against a cycle-level behavioural model.
// Parity checks are compiled in when WB_MUX2_PARITY_EN is defined.
module tb_wb_mux2;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         select;
    logic         in_valid;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         out_valid;
`ifdef WB_MUX2_PARITY_EN
    logic         out_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the write-back register should hold.
    logic [W-1:0] m_q;
    logic         m_v;
    logic         m_par;

    wb_mux2 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0      (in0),
        .in1      (in1),
        .select   (select),
        .in_valid (in_valid),
        .out      (out),
        .out_q    (out_q),
        .out_valid(out_valid)
`ifdef WB_MUX2_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pick(logic s, logic [W-1:0] a, logic [W-1:0] b);
        return s ? b : a;
    endfunction

    function automatic logic even_par(logic [W-1:0] v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return logic'(ones % 2);
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic tick;
        if (!rst_n) begin
            m_q = '0; m_v = 1'b0; m_par = 1'b0;
        end else if (in_valid) begin
            m_q = pick(select, in0, in1); m_v = 1'b1; m_par = even_par(m_q);
        end else begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb;
        in0 = 16'h0006; in1 = 16'hAAAA; select = 1'b0; #1;
        n_checks++;
        if (out !== 16'h0006) begin
            n_fail++; $display("FAIL comb_sel0: out=%h expected=%h", out, 16'h0006);
        end
        select = 1'b1; #1;
        n_checks++;
        if (out !== 16'hAAAA) begin
            n_fail++; $display("FAIL comb_sel1: out=%h expected=%h", out, 16'hAAAA);
        end
        select = 1'b0; #1;
        n_checks++;
        if (out !== 16'h0006) begin
            n_fail++; $display("FAIL comb_toggle: out=%h expected=%h", out, 16'h0006);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; select = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_q !== 16'h0000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: out_q=%h out_valid=%b expected 0000/0", out_q, out_valid);
        end
        n_checks++;
        if (out !== 16'hAAAA) begin
            n_fail++; $display("FAIL comb_in_reset: out=%h expected=%h", out, 16'hAAAA);
        end
`ifdef WB_MUX2_PARITY_EN
        n_checks++;
        if (out_par !== 1'b0) begin
            n_fail++; $display("FAIL reset_par: out_par=%b expected=0", out_par);
        end
`endif
    endtask

    task automatic test_register;
        rst_n = 1'b1; in_valid = 1'b1; select = 1'b1; in1 = 16'hAAAA;
        tick();
        n_checks++;
        if (out_q !== 16'hAAAA || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL first_valid: out_q=%h out_valid=%b expected AAAA/1", out_q, out_valid);
        end
`ifdef WB_MUX2_PARITY_EN
        n_checks++;
        if (out_par !== 1'b0) begin
            n_fail++; $display("FAIL par_aaaa: out_par=%b expected=0", out_par);
        end
`endif
        in_valid = 1'b0; in1 = 16'h1234; select = 1'b0;
        tick();
        n_checks++;
        if (out_q !== 16'hAAAA || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold: out_q=%h out_valid=%b expected AAAA/0", out_q, out_valid);
        end
`ifdef WB_MUX2_PARITY_EN
        in_valid = 1'b1; select = 1'b0; in0 = 16'h0007;
        tick();
        n_checks++;
        if (out_par !== 1'b1 || out_q !== 16'h0007) begin
            n_fail++; $display("FAIL par_0007: out_par=%b out_q=%h expected 1/0007", out_par, out_q);
        end
        in_valid = 1'b0; in0 = 16'h0003;
        tick();
        n_checks++;
        if (out_par !== 1'b1) begin
            n_fail++; $display("FAIL par_hold: out_par=%b expected=1", out_par);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_seq [3] = '{16'h0006, 16'hAAAA, 16'h0006};
        logic         sel_seq [3] = '{1'b0, 1'b1, 1'b0};
        in0 = 16'h0006; in1 = 16'hAAAA; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            select = sel_seq[i];
            tick();
            n_checks++;
            if (out_q !== exp_seq[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: out_q=%h out_valid=%b expected %h/1", i, out_q, out_valid, exp_seq[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            in0      = W'($urandom);
            in1      = W'($urandom);
            select   = logic'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 15) != 0);
            #1;
            n_checks++;
            if (out !== pick(select, in0, in1)) begin
                n_fail++; $display("FAIL rnd_comb[%0d]: out=%h expected=%h", i, out, pick(select, in0, in1));
            end
            tick();
            n_checks++;
            if (out_q !== m_q || out_valid !== m_v) begin
                n_fail++;
                $display("FAIL rnd_reg[%0d]: out_q=%h out_valid=%b expected %h/%b", i, out_q, out_valid, m_q, m_v);
            end
`ifdef WB_MUX2_PARITY_EN
            n_checks++;
            if (out_par !== m_par) begin
                n_fail++; $display("FAIL rnd_par[%0d]: out_par=%b expected=%b", i, out_par, m_par);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; select = 1'b0; in0 = '0; in1 = '0;
        m_q = 'x; m_v = 1'bx; m_par = 1'bx;
        @(negedge clk);
        test_comb();
        test_reset();
        test_register();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
